stream_narrow: RTL and testbench



---
 rtl/stream_tools_pkg.sv | 18 +
 rtl/stream_hold_reg.sv | 42 ++++
 rtl/stream_narrow.sv | 131 +++++++++++++
 tb/tb_stream_narrow.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_tools_pkg.sv
// Shared stream helpers used by the widen/narrow blocks and their benches.
package stream_tools;

  // Widest packed word the lane helper accepts; callers zero-extend into it.
  localparam int unsigned STREAM_MAX_WIDTH = 1024;

  // Extract lane `lane` (each `width` bits, lane 0 in the LSBs) of a packed word.
  function automatic logic [STREAM_MAX_WIDTH-1:0] stream_lane_sel(
    input logic [STREAM_MAX_WIDTH-1:0] word,
    input int unsigned                 width,
    input int unsigned                 lane
  );
    logic [STREAM_MAX_WIDTH-1:0] mask;
    mask = {STREAM_MAX_WIDTH{1'b1}} >> (STREAM_MAX_WIDTH - width);
    return (word >> (width * lane)) & mask;
  endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// One-entry holding register: a payload word with first/last sideband and a valid flag.
module stream_hold_reg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_first,
  input  logic                  load_last,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  first,
  output logic                  last,
  output logic                  valid
);

  // Occupancy: load fills the entry, pop empties it; load wins if both occur.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  // Payload capture on load.
  // NOTE: payload flops carry no reset; they are only observed while valid is
  // set, so resetting them would just add reset routing to a wide datapath.
  always_ff @(posedge clk) begin
    if (load) begin
      data  <= load_data;
      first <= load_first;
      last  <= load_last;
    end
  end

endmodule

// File: rtl/stream_narrow.sv
// Unpacks each wide word of N packed samples into N narrow samples, lane 0 first,
// one per cycle. A one-word hold register absorbs a word arriving mid-unpack.
module stream_narrow
  import stream_tools::*;
#(
  parameter int unsigned STREAM_WIDTH         = 8,
  parameter int unsigned STREAM_IN_MULTIPLIER = 3,
  parameter int unsigned STREAM_IN_WIDTH      = STREAM_WIDTH * STREAM_IN_MULTIPLIER
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STREAM_IN_WIDTH-1:0] stream_in,
  input  logic                       stream_in_valid,
  input  logic                       stream_in_first,
  input  logic                       stream_in_last,
  output logic                       stream_in_ready,
  output logic                       stream_in_overflow,
  output logic [STREAM_WIDTH-1:0]    stream_out,
  output logic                       stream_out_valid,
  output logic                       stream_out_first,
  output logic                       stream_out_last
);

  localparam int unsigned N     = STREAM_IN_MULTIPLIER;
  localparam int unsigned W     = STREAM_WIDTH;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SR_W  = (N > 1) ? (N - 1) * W : W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic                       hold_valid;
  logic                       hold_first;
  logic                       hold_last;
  logic [STREAM_IN_WIDTH-1:0] hold_data;

  logic                       accept;
  logic                       load_en;
  logic                       hold_load;
  logic                       hold_pop;
  logic [STREAM_IN_WIDTH-1:0] src_data;
  logic                       src_first;
  logic                       src_last;

  logic                       busy;       // lanes 1..N-1 of the current word still pending
  logic [CNT_W-1:0]           cnt;        // index of the next lane to emit
  logic [SR_W-1:0]            sr;         // remaining lanes, next one in the LSBs
  logic                       word_last;  // last flag of the word being unpacked

  // Ready comes straight from the hold flop, so there is no input-to-ready path.
  assign stream_in_ready = !hold_valid;
  assign accept          = stream_in_valid && stream_in_ready;

  // A new word starts once the previous word's final lane is on the output,
  // so consecutive words stream with no bubble. A held word takes priority;
  // ready is low while it waits, so it never competes with a fresh input.
  assign load_en   = !busy && (hold_valid || accept);
  assign hold_load = accept && !load_en;
  assign hold_pop  = load_en && hold_valid;

  assign src_data  = hold_valid ? hold_data  : stream_in;
  assign src_first = hold_valid ? hold_first : stream_in_first;
  assign src_last  = hold_valid ? hold_last  : stream_in_last;

  stream_hold_reg #(
    .DATA_WIDTH (STREAM_IN_WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .pop        (hold_pop),
    .load_data  (stream_in),
    .load_first (stream_in_first),
    .load_last  (stream_in_last),
    .data       (hold_data),
    .first      (hold_first),
    .last       (hold_last),
    .valid      (hold_valid)
  );

  // Unpack control and output register: load lane 0, then walk the remaining lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy               <= 1'b0;
      cnt                <= '0;
      word_last          <= 1'b0;
      stream_out         <= '0;
      stream_out_valid   <= 1'b0;
      stream_out_first   <= 1'b0;
      stream_out_last    <= 1'b0;
      stream_in_overflow <= 1'b0;
    end else begin
      if (stream_in_valid && !stream_in_ready) begin
        stream_in_overflow <= 1'b1;
      end

      if (load_en) begin
        stream_out       <= W'(stream_lane_sel(STREAM_MAX_WIDTH'(src_data), W, 0));
        stream_out_valid <= 1'b1;
        stream_out_first <= src_first;
        stream_out_last  <= src_last && (N == 1);
        word_last        <= src_last;
        cnt              <= CNT_W'(1);
        busy             <= (N > 1);
      end else if (busy) begin
        stream_out       <= sr[W-1:0];
        stream_out_valid <= 1'b1;
        stream_out_first <= 1'b0;
        stream_out_last  <= word_last && (cnt == CNT_LAST);
        if (cnt == CNT_LAST) begin
          cnt  <= '0;
          busy <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        stream_out_valid <= 1'b0;
        stream_out_first <= 1'b0;
        stream_out_last  <= 1'b0;
      end
    end
  end

  // Remaining-lane shift register: capture lanes 1..N-1 on load, shift one lane per emit.
  always_ff @(posedge clk) begin
    if (load_en) begin
      sr <= SR_W'(src_data >> W);
    end else if (busy) begin
      sr <= sr >> W;
    end
  end

endmodule

// File: tb/tb_stream_narrow.sv
// Self-checking bench for stream_narrow: directed scenarios plus random traffic,
// checked cycle by cycle against a schedule-based reference model.
module tb_stream_narrow;

  localparam int W = 8;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;

  // N=3 instance
  logic [N*W-1:0] in_data;
  logic           in_valid, in_first, in_last;
  logic           in_ready, ovf;
  logic [W-1:0]   out_data;
  logic           out_valid, out_first, out_last;

  // N=1 instance
  logic [W-1:0]   in1_data;
  logic           in1_valid, in1_first, in1_last;
  logic           in1_ready, ovf1;
  logic [W-1:0]   out1_data;
  logic           out1_valid, out1_first, out1_last;

  always #5 clk = ~clk;

  stream_narrow #(
    .STREAM_WIDTH         (W),
    .STREAM_IN_MULTIPLIER (N)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stream_in          (in_data),
    .stream_in_valid    (in_valid),
    .stream_in_first    (in_first),
    .stream_in_last     (in_last),
    .stream_in_ready    (in_ready),
    .stream_in_overflow (ovf),
    .stream_out         (out_data),
    .stream_out_valid   (out_valid),
    .stream_out_first   (out_first),
    .stream_out_last    (out_last)
  );

  stream_narrow #(
    .STREAM_WIDTH         (W),
    .STREAM_IN_MULTIPLIER (1)
  ) dut1 (
    .clk                (clk),
    .rst                (rst),
    .stream_in          (in1_data),
    .stream_in_valid    (in1_valid),
    .stream_in_first    (in1_first),
    .stream_in_last     (in1_last),
    .stream_in_ready    (in1_ready),
    .stream_in_overflow (ovf1),
    .stream_out         (out1_data),
    .stream_out_valid   (out1_valid),
    .stream_out_first   (out1_first),
    .stream_out_last    (out1_last)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: each accepted word is scheduled to occupy output edges
  // s..s+N-1 with s = max(accept edge, first free edge). The word waits in the
  // hold register (ready low) for edges strictly after acceptance up to s.
  int cyc;
  int next_free;
  int last_e, last_s;
  bit exp_ovf;
  logic [W+1:0] exp_map [int];   // {first, last, data} expected after a given edge

  logic [W-1:0] rx_data  [$];
  bit           rx_first [$];
  bit           rx_last  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [W+1:0] e;
    if (exp_map.exists(cyc)) begin
      e = exp_map[cyc];
      exp_map.delete(cyc);
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data",  32'(out_data),  32'(e[W-1:0]));
      check("out_first", 32'(out_first), 32'(e[W+1]));
      check("out_last",  32'(out_last),  32'(e[W]));
    end else begin
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_first", 32'(out_first), 32'd0);
      check("idle_last",  32'(out_last),  32'd0);
    end
    check("overflow", 32'(ovf), 32'(exp_ovf));
    if (out_valid === 1'b1) begin
      rx_data.push_back(out_data);
      rx_first.push_back(out_first);
      rx_last.push_back(out_last);
    end
  endtask

  // One clock of N=3 traffic. Called just after a falling edge.
  task automatic drive_cycle(input bit v, input logic [N*W-1:0] d, input bit f,
                             input bit l, input bit honour, output bit accepted);
    int e_n;
    int s;
    bit mready;
    e_n    = cyc + 1;
    mready = !(last_e < e_n && e_n <= last_s);
    check("ready", 32'(in_ready), 32'(mready));
    if (honour && !mready) v = 1'b0;
    in_valid = v;
    in_data  = d;
    in_first = f;
    in_last  = l;
    accepted = v && mready;
    if (accepted) begin
      s = (e_n > next_free) ? e_n : next_free;
      for (int k = 0; k < N; k++) begin
        exp_map[s + k] = {f && (k == 0), l && (k == N - 1), d[k*W +: W]};
      end
      next_free = s + N;
      last_e    = e_n;
      last_s    = s;
    end else if (v) begin
      exp_ovf = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    in_valid = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  task automatic send_word(input logic [N*W-1:0] d, input bit f, input bit l);
    bit acc;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      drive_cycle(1'b1, d, f, l, 1'b1, acc);
      done = acc;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in1_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    exp_map.delete();
    next_free = cyc + 1;
    last_e    = -10;
    last_s    = -10;
    exp_ovf   = 1'b0;
    check("rst_valid",    32'(out_valid),  32'd0);
    check("rst_first",    32'(out_first),  32'd0);
    check("rst_last",     32'(out_last),   32'd0);
    check("rst_data",     32'(out_data),   32'd0);
    check("rst_overflow", 32'(ovf),        32'd0);
    check("rst_valid_n1", 32'(out1_valid), 32'd0);
    rx_data.delete();
    rx_first.delete();
    rx_last.delete();
  endtask

  // One clock of N=1 traffic: the sample must reappear unchanged one cycle later.
  task automatic step1(input bit v, input logic [W-1:0] d, input bit f, input bit l);
    check("n1_ready", 32'(in1_ready), 32'd1);
    in1_valid = v;
    in1_data  = d;
    in1_first = f;
    in1_last  = l;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    in1_valid = 1'b0;
    check("n1_valid", 32'(out1_valid), 32'(v));
    if (v) begin
      check("n1_data",  32'(out1_data),  32'(d));
      check("n1_first", 32'(out1_first), 32'(f));
      check("n1_last",  32'(out1_last),  32'(l));
    end
    check("n1_overflow", 32'(ovf1), 32'd0);
    check_outputs();
  endtask

  initial begin
    logic [W-1:0]   bytes [12];
    logic [N*W-1:0] word;
    bit             acc;

    rst       = 1'b1;
    in_valid  = 1'b0; in_data  = '0; in_first  = 1'b0; in_last  = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_first = 1'b0; in1_last = 1'b0;
    cyc       = 0;
    next_free = 0;
    last_e    = -10;
    last_s    = -10;
    exp_ovf   = 1'b0;

    @(negedge clk);
    do_reset();

    // Single word: 0x11, 0x22, 0x33 on consecutive cycles.
    send_word(24'h332211, 1'b1, 1'b1);
    idle(4);

    // Back-to-back words honouring ready: nine contiguous samples.
    rx_data.delete(); rx_first.delete(); rx_last.delete();
    send_word(24'h030201, 1'b1, 1'b0);
    send_word(24'h060504, 1'b0, 1'b0);
    send_word(24'h090807, 1'b0, 1'b1);
    idle(6);
    check("b2b_count", 32'(rx_data.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < rx_data.size()) check("b2b_data", 32'(rx_data[i]), 32'(i + 1));
    end

    // Overflow: third word pushed while the hold register is full.
    send_word(24'hA3A2A1, 1'b1, 1'b0);
    send_word(24'hB3B2B1, 1'b0, 1'b1);
    drive_cycle(1'b1, 24'hDEADBE, 1'b1, 1'b1, 1'b0, acc);
    check("ovf_rejected", 32'(acc), 32'd0);
    idle(8);
    do_reset();

    // Reset mid-word: 0x22/0x33 must never appear.
    send_word(24'h332211, 1'b1, 1'b1);
    do_reset();
    idle(4);

    // N=1 passthrough.
    step1(1'b1, 8'hAB, 1'b1, 1'b0);
    step1(1'b1, 8'hCD, 1'b0, 1'b1);
    step1(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step1(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    // Round trip: a 12-sample frame packed three per word, lane 0 first.
    rx_data.delete(); rx_first.delete(); rx_last.delete();
    for (int i = 0; i < 12; i++) bytes[i] = 8'($urandom);
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < N; k++) word[k*W +: W] = bytes[w*N + k];
      send_word(word, w == 0, w == 3);
    end
    idle(6);
    check("rt_count", 32'(rx_data.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < rx_data.size()) begin
        check("rt_data",  32'(rx_data[i]),  32'(bytes[i]));
        check("rt_first", 32'(rx_first[i]), 32'(i == 0));
        check("rt_last",  32'(rx_last[i]),  32'(i == 11));
      end
    end

    // Random traffic, occasionally ignoring ready to provoke overflow.
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 24'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 60) != 0, acc);
    end
    idle(8);
    do_reset();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
